// File: rtl/word32_serializer.sv
// 32-bit parallel-to-serial converter with valid/ready handshakes on both sides.
// Optional even-parity trailer bit when SER_PARITY_EN is defined.
module word32_serializer #(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic        sout,
   output logic        sout_valid,
   input  logic        sout_ready,
   output logic        busy,
   output logic        word_done
);

`ifdef SER_PARITY_EN
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2,
      DONE   = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;
`endif

   state_t      state_q, state_d;
   logic [31:0] shreg_q, shreg_d;
   logic [4:0]  cnt_q, cnt_d;
`ifdef SER_PARITY_EN
   logic        par_q, par_d;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shreg_q <= '0;
         cnt_q   <= '0;
`ifdef SER_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         cnt_q   <= cnt_d;
`ifdef SER_PARITY_EN
         par_q   <= par_d;
`endif
      end
   end

   always_comb begin
      state_d    = state_q;
      shreg_d    = shreg_q;
      cnt_d      = cnt_q;
`ifdef SER_PARITY_EN
      par_d      = par_q;
`endif
      din_ready  = 1'b0;
      sout       = 1'b0;
      sout_valid = 1'b0;
      busy       = 1'b1;
      word_done  = 1'b0;
      unique case (state_q)
         IDLE: begin
            din_ready = 1'b1;
            busy      = 1'b0;
            if (din_valid) begin
               shreg_d = din;
               cnt_d   = 5'd0;
               state_d = SHIFT;
`ifdef SER_PARITY_EN
               par_d   = ^din;
`endif
            end
         end
         SHIFT: begin
            sout_valid = 1'b1;
            sout       = MSB_FIRST ? shreg_q[31] : shreg_q[0];
            if (sout_ready) begin
               shreg_d = MSB_FIRST ? {shreg_q[30:0], 1'b0}
                                   : {1'b0, shreg_q[31:1]};
               cnt_d   = cnt_q + 5'd1;
               // Last bit: park the counter rather than wrap into a second pass.
               if (cnt_q == 5'd31) begin
                  cnt_d = 5'd0;
`ifdef SER_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = DONE;
`endif
               end
            end
         end
`ifdef SER_PARITY_EN
         PARITY: begin
            sout_valid = 1'b1;
            sout       = par_q;
            if (sout_ready) state_d = DONE;
         end
`endif
         DONE: begin
            word_done = 1'b1;
            state_d   = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_word32_serializer.sv
// Scoreboard bench for word32_serializer: one MSB-first and one LSB-first
// instance share stimulus; expected bits are queued at acceptance.
module tb_word32_serializer;

`ifdef SER_PARITY_EN
   localparam int NB = 33;
`else
   localparam int NB = 32;
`endif

   logic        clk;
   logic        rst_n;
   logic [31:0] din;
   logic        din_valid;
   logic        sout_ready;
   logic        a_din_ready, a_sout, a_sout_valid, a_busy, a_word_done;
   logic        b_din_ready, b_sout, b_sout_valid, b_busy, b_word_done;

   int checks = 0;
   int passed = 0;
   bit qa[$];
   bit qb[$];

   word32_serializer #(.MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .din_ready(a_din_ready), .sout(a_sout), .sout_valid(a_sout_valid),
      .sout_ready(sout_ready), .busy(a_busy), .word_done(a_word_done)
   );

   word32_serializer #(.MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
      .din_ready(b_din_ready), .sout(b_sout), .sout_valid(b_sout_valid),
      .sout_ready(sout_ready), .busy(b_busy), .word_done(b_word_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load_qa(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) qa.push_back(w[i]);
`ifdef SER_PARITY_EN
      qa.push_back(^w);
`endif
   endtask

   task automatic test_reset;
      rst_n = 1'b0; din = 32'h1; din_valid = 1'b1; sout_ready = 1'b1;
      tick; tick;
      rst_n = 1'b1; din_valid = 1'b0;
      checks++;
      if ({a_busy, a_sout_valid, a_word_done, a_sout, a_din_ready} !== 5'b00001)
         $display("FAIL reset_msb: got %b want 00001",
                  {a_busy, a_sout_valid, a_word_done, a_sout, a_din_ready});
      else passed++;
      checks++;
      if ({b_busy, b_sout_valid, b_word_done, b_sout, b_din_ready} !== 5'b00001)
         $display("FAIL reset_lsb: got %b want 00001",
                  {b_busy, b_sout_valid, b_word_done, b_sout, b_din_ready});
      else passed++;
      tick;
      checks++;
      if ({a_busy, a_sout_valid, a_din_ready} !== 3'b001)
         $display("FAIL reset_idle: got %b want 001",
                  {a_busy, a_sout_valid, a_din_ready});
      else passed++;
   endtask

   task automatic test_msb_first;
      bit e;
      qa.delete();
      for (int i = 0; i < 32; i++) qa.push_back(i == 0 || i == 31);
`ifdef SER_PARITY_EN
      qa.push_back(1'b0);
`endif
      din = 32'h8000_0001; din_valid = 1'b1; sout_ready = 1'b1;
      tick;
      din_valid = 1'b0;
      for (int c = 1; c <= NB; c++) begin
         e = (qa.size() != 0) ? qa[0] : 1'b0;
         checks++;
         if (a_sout_valid !== 1'b1 || qa.size() == 0 || a_sout !== e)
            $display("FAIL msb_bit c%0d: got %b valid %b want %b", c,
                     a_sout, a_sout_valid, e);
         else passed++;
         if (qa.size() != 0) void'(qa.pop_front());
         tick;
      end
      checks++;
      if ({a_word_done, a_sout_valid, a_sout} !== 3'b100)
         $display("FAIL msb_done: got %b want 100",
                  {a_word_done, a_sout_valid, a_sout});
      else passed++;
      tick;
      checks++;
      if ({a_din_ready, a_word_done, a_busy} !== 3'b100)
         $display("FAIL msb_idle: got %b want 100",
                  {a_din_ready, a_word_done, a_busy});
      else passed++;
   endtask

   task automatic test_lsb_first;
      bit e;
      qb.delete();
      for (int i = 0; i < 32; i++) qb.push_back(i >= 4 && i < 8);
`ifdef SER_PARITY_EN
      qb.push_back(1'b0);
`endif
      din = 32'h0000_00F0; din_valid = 1'b1; sout_ready = 1'b1;
      tick;
      din_valid = 1'b0;
      for (int c = 1; c <= NB; c++) begin
         e = (qb.size() != 0) ? qb[0] : 1'b0;
         checks++;
         if (b_sout_valid !== 1'b1 || qb.size() == 0 || b_sout !== e)
            $display("FAIL lsb_bit c%0d: got %b valid %b want %b", c,
                     b_sout, b_sout_valid, e);
         else passed++;
         if (qb.size() != 0) void'(qb.pop_front());
         tick;
      end
      checks++;
      if ({b_word_done, b_sout_valid} !== 2'b10)
         $display("FAIL lsb_done: got %b want 10", {b_word_done, b_sout_valid});
      else passed++;
      tick;
   endtask

   task automatic test_stall;
      int xf = 0, dn = 0, dc = 0;
      bit e;
      qa.delete();
      load_qa(32'hA5A5_A5A5);
      din = 32'hA5A5_A5A5; din_valid = 1'b1; sout_ready = 1'b0;
      tick;
      din_valid = 1'b0;
      for (int c = 1; c <= 2 * NB + 6; c++) begin
         sout_ready = (c % 2 == 0);
         if (a_word_done === 1'b1) begin dn++; dc = c; end
         if (a_sout_valid === 1'b1) begin
            e = (qa.size() != 0) ? qa[0] : 1'b0;
            checks++;
            if (qa.size() == 0 || a_sout !== e)
               $display("FAIL stall_bit c%0d: got %b want %b q%0d", c,
                        a_sout, e, qa.size());
            else passed++;
            if (sout_ready && qa.size() != 0) begin
               void'(qa.pop_front());
               xf++;
            end
         end
         tick;
      end
      sout_ready = 1'b1;
      checks++;
      if (xf != NB) $display("FAIL stall_xfers: got %0d want %0d", xf, NB);
      else passed++;
      checks++;
      if (dn != 1) $display("FAIL stall_done_cnt: got %0d want 1", dn);
      else passed++;
      checks++;
      if (dc != 2 * NB + 1)
         $display("FAIL stall_done_cyc: got %0d want %0d", dc, 2 * NB + 1);
      else passed++;
   endtask

   task automatic test_back_to_back;
      int xf = 0, dn = 0;
      bit e;
      qa.delete();
      load_qa(32'h1234_5678);
      load_qa(32'hCAFE_BABE);
      din = 32'h1234_5678; din_valid = 1'b1; sout_ready = 1'b1;
      tick;
      din = 32'hCAFE_BABE;
      for (int c = 1; c <= 2 * NB + 8; c++) begin
         if (c == NB + 1) begin
            checks++;
            if (a_din_ready !== 1'b0)
               $display("FAIL b2b_ready_done: got %b want 0", a_din_ready);
            else passed++;
         end
         if (c == NB + 2) begin
            checks++;
            if (a_din_ready !== 1'b1)
               $display("FAIL b2b_ready_idle: got %b want 1", a_din_ready);
            else passed++;
         end
         if (a_word_done === 1'b1) dn++;
         if (a_sout_valid === 1'b1) begin
            e = (qa.size() != 0) ? qa[0] : 1'b0;
            checks++;
            if (qa.size() == 0 || a_sout !== e)
               $display("FAIL b2b_bit c%0d: got %b want %b", c, a_sout, e);
            else passed++;
            if (qa.size() != 0) void'(qa.pop_front());
            xf++;
         end
         tick;
         if (c == NB + 2) din_valid = 1'b0;
      end
      checks++;
      if (xf != 2 * NB || qa.size() != 0)
         $display("FAIL b2b_xfers: got %0d left %0d want %0d", xf, qa.size(),
                  2 * NB);
      else passed++;
      checks++;
      if (dn != 2) $display("FAIL b2b_done_cnt: got %0d want 2", dn);
      else passed++;
   endtask

   task automatic test_reset_mid;
      int bad = 0;
      din = 32'hFFFF_FFFF; din_valid = 1'b1; sout_ready = 1'b1;
      tick;
      din_valid = 1'b0;
      repeat (11) tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      checks++;
      if ({a_busy, a_sout_valid, a_word_done, a_din_ready} !== 4'b0001)
         $display("FAIL midrst_state: got %b want 0001",
                  {a_busy, a_sout_valid, a_word_done, a_din_ready});
      else passed++;
      for (int c = 0; c < 40; c++) begin
         if (a_sout_valid || a_word_done || b_sout_valid || b_word_done) bad++;
         tick;
      end
      checks++;
      if (bad != 0) $display("FAIL midrst_quiet: got %0d active cycles want 0", bad);
      else passed++;
   endtask

`ifdef SER_PARITY_EN
   task automatic test_parity;
      logic [31:0] w [2];
      bit          p [2];
      w[0] = 32'h0000_0007; p[0] = 1'b1;
      w[1] = 32'h0000_0003; p[1] = 1'b0;
      for (int k = 0; k < 2; k++) begin
         din = w[k]; din_valid = 1'b1; sout_ready = 1'b1;
         tick;
         din_valid = 1'b0;
         repeat (32) tick;
         checks++;
         if ({a_sout_valid, a_sout, b_sout_valid, b_sout} !== {1'b1, p[k], 1'b1, p[k]})
            $display("FAIL parity_bit w%0d: got %b%b %b%b want 1%b", k,
                     a_sout_valid, a_sout, b_sout_valid, b_sout, p[k]);
         else passed++;
         tick;
         checks++;
         if ({a_word_done, a_sout_valid} !== 2'b10)
            $display("FAIL parity_done w%0d: got %b want 10", k,
                     {a_word_done, a_sout_valid});
         else passed++;
         tick; tick;
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0; din = '0; din_valid = 1'b0; sout_ready = 1'b0;
      test_reset;
      test_msb_first;
      test_lsb_first;
      test_stall;
      tick;
      test_back_to_back;
      test_reset_mid;
`ifdef SER_PARITY_EN
      test_parity;
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/word32_serializer.md
WORD32_SERIALIZER -- requirements
Module: word32_serializer

Interface
REQ-001 Parameter: MSB_FIRST, default 1, bit order (1 = bit 31 first, 0 = bit 0 first).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 din  input  32  parallel word to serialize.
REQ-005 din_valid  input  1  din holds a valid word.
REQ-006 din_ready  output  1  block can accept a word this cycle.
REQ-007 sout  output  1  current serial bit.
REQ-008 sout_valid  output  1  sout holds a valid bit.
REQ-009 sout_ready  input  1  consumer takes sout this cycle.
REQ-010 busy  output  1  a word is in progress (state != IDLE).
REQ-011 word_done  output  1  one-cycle pulse after the final bit of a word is taken.

Function
REQ-012 States SHALL be IDLE, SHIFT, PARITY (only with SER_PARITY_EN) and DONE, held in a registered state variable.
REQ-013 din_ready SHALL be 1 only in IDLE; a word is accepted on an edge where din_valid=1 and din_ready=1.
REQ-014 On acceptance, din SHALL load a 32-bit shift register, the 5-bit bit counter SHALL clear to 0, and state SHALL go to SHIFT.
REQ-015 The first bit SHALL be on sout with sout_valid=1 in the cycle after acceptance (latency 1).
REQ-016 In SHIFT, sout SHALL be shreg[31] when MSB_FIRST=1, else shreg[0]; sout_valid SHALL be 1.
REQ-017 A bit transfer occurs on an edge where sout_valid=1 and sout_ready=1; the register then shifts by one toward the output end and the counter increments.
REQ-018 With sout_ready=0, sout, sout_valid, the register and the counter SHALL hold unchanged for any number of cycles.
REQ-019 On the transfer of bit 31 (counter=31), state SHALL go to DONE, or to PARITY when SER_PARITY_EN is defined; the counter SHALL NOT wrap into a second pass.
REQ-020 DONE SHALL last exactly one cycle with word_done=1 and sout_valid=0, then return to IDLE.
REQ-021 Minimum word period SHALL be 34 cycles with sout_ready tied 1: 1 accept + 32 bits + 1 DONE (35 with parity).
REQ-022 din and din_valid SHALL be ignored outside IDLE; a word presented while busy is not captured.
REQ-023 In IDLE and DONE, sout SHALL be 0 and sout_valid 0.

Reset
REQ-024 On an edge with rst_n=0, state SHALL be IDLE and shreg, counter, parity accumulator, sout, sout_valid, busy and word_done SHALL be 0; din_ready SHALL be 1 from the next cycle.
REQ-025 Reset asserted mid-word SHALL abandon the word with no word_done pulse; no partial bits SHALL be emitted afterwards.
REQ-026 Reset SHALL take priority over any simultaneous handshake on the same edge.

Configuration
REQ-027 Macro SER_PARITY_EN: when defined, after bit 31 the block SHALL enter PARITY and emit one extra bit equal to the XOR of all 32 data bits (even parity), under the same sout_valid/sout_ready handshake, then go to DONE.
REQ-028 Without SER_PARITY_EN, the PARITY state, parity register and logic SHALL be absent and bit 31 SHALL lead straight to DONE.

Verification
REQ-029 Reset, MSB_FIRST=1, din=32'h8000_0001 accepted, sout_ready=1 -> sout sequence 1, thirty 0s, 1 on cycles 1..32 after accept; word_done=1 on cycle 33; din_ready=1 on cycle 34.
REQ-030 MSB_FIRST=0, din=32'h0000_00F0 -> LSB first: 0,0,0,0,1,1,1,1 then twenty-four 0s.
REQ-031 din=32'hA5A5_A5A5, sout_ready toggled 1/0 every cycle -> bits unchanged during stalls; 32 transfers total; word_done exactly once, 64 cycles after first bit valid.
REQ-032 din_valid held 1 with new words while busy -> only the first word is serialized; the second is captured only after DONE returns to IDLE.
REQ-033 rst_n=0 for one edge after bit 10 of din=32'hFFFF_FFFF -> next cycle sout_valid=0, busy=0, din_ready=1, no word_done pulse.
REQ-034 SER_PARITY_EN defined, din=32'h0000_0007 -> 33rd bit=1; din=32'h0000_0003 -> 33rd bit=0; word_done one cycle after the parity transfer.
